// File: rtl/sm83_fetch_pkg.sv
// Shared constants for the SM83 instruction-fetch front end: default bus widths
// and the two reset vectors used by boot ROM and cartridge entry.
package sm83_fetch_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    localparam logic [15:0] BOOT_PC       = 16'h0000;
    localparam logic [15:0] CART_ENTRY_PC = 16'h0100;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched bytes with their addresses. Flush empties it
// in one edge; the producer guarantees it never pushes while full.
module fetch_queue #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         head_valid,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_pop;

    assign do_pop     = pop & (count != '0);
    assign head_valid = (count != '0);
    assign head_data  = entries[rd_ptr];
    assign level      = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; head_data is only meaningful while head_valid.
    always_ff @(posedge clk) begin
        if (push && !flush)
            entries[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/prefetch_unit.sv
// Pipelined SM83 instruction prefetcher: issues sequential byte reads, tracks
// in-flight reads in a latency-matched delay line and queues returned bytes.
module prefetch_unit
    import sm83_fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                DEPTH    = 4,
    parameter int                MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(BOOT_PC)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_en,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_cs,
    output logic                        mem_oe,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        op_valid,
    output logic [DATA_W-1:0]           op_data,
    output logic [ADDR_W-1:0]           op_pc,
    input  logic                        op_ready,
    output logic [$clog2(DEPTH+1)-1:0]  level
);

    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int SUM_W = LVL_W + 3;
    localparam int Q_W   = DATA_W + ADDR_W;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [MEM_LAT-1:0] dl_valid;
    logic [ADDR_W-1:0]  dl_pc [MEM_LAT];
    logic [SUM_W-1:0]   outstanding;
    logic               credit_ok;
    logic               q_pop;
    logic [Q_W-1:0]     q_head;

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < MEM_LAT; i++)
            outstanding = outstanding + SUM_W'(dl_valid[i]);
    end

    // Every in-flight read already owns a queue slot; a same-cycle pop is not
    // credited, which keeps op_ready out of the mem_cs path.
    assign credit_ok = (SUM_W'(level) + outstanding) < SUM_W'(DEPTH);
    assign mem_cs    = rst & fetch_en & ~redirect & credit_ok;
    assign mem_oe    = dl_valid[MEM_LAT-1] & ~redirect;
    assign mem_addr  = fetch_pc;

    // Handshake: a byte transfers on a cycle where op_valid & op_ready are both
    // high and redirect is low; op_valid never depends on op_ready.
    assign q_pop = op_valid & op_ready & ~redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            dl_valid <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            dl_valid <= '0;
        end else begin
            if (mem_cs)
                fetch_pc <= fetch_pc + 1'b1;
            dl_valid[0] <= mem_cs;
            for (int i = 1; i < MEM_LAT; i++)
                dl_valid[i] <= dl_valid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dl_pc[0] <= fetch_pc;
        for (int i = 1; i < MEM_LAT; i++)
            dl_pc[i] <= dl_pc[i-1];
    end

    fetch_queue #(
        .WIDTH (Q_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (mem_oe),
        .push_data  ({mem_rdata, dl_pc[MEM_LAT-1]}),
        .pop        (q_pop),
        .flush      (redirect),
        .head_valid (op_valid),
        .head_data  (q_head),
        .level      (level)
    );

    assign op_data = q_head[Q_W-1 -: DATA_W];
    assign op_pc   = q_head[ADDR_W-1:0];

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: a MEM_LAT=1/DEPTH=4 unit under full control,
// plus MEM_LAT=3 units with DEPTH=4 and DEPTH=8 for sustained-rate checks.
module tb_prefetch_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main unit: MEM_LAT=1, DEPTH=4
    logic        fetch_en, redirect, op_ready;
    logic [15:0] redirect_pc, mem_addr, op_pc;
    logic        mem_cs, mem_oe, op_valid;
    logic [7:0]  mem_rdata, op_data;
    logic [2:0]  level;

    // rate units: MEM_LAT=3, DEPTH=4 and DEPTH=8, always enabled and ready
    logic        en_r = 1'b1, rdy_r = 1'b1, redir_r = 1'b0;
    logic [15:0] rpc_r = 16'h0000;
    logic [15:0] mem_addr_3, op_pc_3, mem_addr_8, op_pc_8;
    logic        mem_cs_3, mem_oe_3, op_valid_3, mem_cs_8, mem_oe_8, op_valid_8;
    logic [7:0]  mem_rdata_3, op_data_3, mem_rdata_8, op_data_8;
    logic [2:0]  level_3;
    logic [3:0]  level_8;

    int tests = 0;
    int failed = 0;
    logic [23:0] exp_q[$];

    prefetch_unit #(.DEPTH(4), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_addr(mem_addr), .mem_cs(mem_cs),
        .mem_oe(mem_oe), .mem_rdata(mem_rdata), .op_valid(op_valid),
        .op_data(op_data), .op_pc(op_pc), .op_ready(op_ready), .level(level)
    );

    prefetch_unit #(.DEPTH(4), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .fetch_en(en_r), .redirect(redir_r),
        .redirect_pc(rpc_r), .mem_addr(mem_addr_3), .mem_cs(mem_cs_3),
        .mem_oe(mem_oe_3), .mem_rdata(mem_rdata_3), .op_valid(op_valid_3),
        .op_data(op_data_3), .op_pc(op_pc_3), .op_ready(rdy_r), .level(level_3)
    );

    prefetch_unit #(.DEPTH(8), .MEM_LAT(3)) dut8 (
        .clk(clk), .rst(rst), .fetch_en(en_r), .redirect(redir_r),
        .redirect_pc(rpc_r), .mem_addr(mem_addr_8), .mem_cs(mem_cs_8),
        .mem_oe(mem_oe_8), .mem_rdata(mem_rdata_8), .op_valid(op_valid_8),
        .op_data(op_data_8), .op_pc(op_pc_8), .op_ready(rdy_r), .level(level_8)
    );

    // memory models: data byte = low address byte, returned MEM_LAT cycles later
    logic [7:0] m1;
    logic [7:0] m3 [3];
    logic [7:0] m8 [3];
    always @(posedge clk) begin
        m1    <= mem_addr[7:0];
        m3[0] <= mem_addr_3[7:0]; m3[1] <= m3[0]; m3[2] <= m3[1];
        m8[0] <= mem_addr_8[7:0]; m8[1] <= m8[0]; m8[2] <= m8[1];
    end
    assign mem_rdata   = m1;
    assign mem_rdata_3 = m3[2];
    assign mem_rdata_8 = m8[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for a while, checks reset values, releases just after a
    // rising edge so the caller starts in cycle 0.
    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", op_valid, 0);
        check("rst_level", level, 0);
        check("rst_cs", mem_cs, 0);
        check("rst_oe", mem_oe, 0);
        check("rst_addr", mem_addr, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic pop_compare(input string tag);
        logic [23:0] e;
        check({tag, "_has_exp"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_pc"}, op_pc, e[23:8]);
            check({tag, "_data"}, op_data, e[7:0]);
        end
    endtask

    task automatic run_redirect(input logic [15:0] tgt);
        logic [15:0] p;
        redirect = 1'b1; redirect_pc = tgt; op_ready = 1'b1;
        @(negedge clk);
        check("r_cs_void", mem_cs, 0);
        check("r_oe_void", mem_oe, 0);
        advance();
        redirect = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            p = tgt + 16'(i);
            exp_q.push_back({p, p[7:0]});
        end
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 1) begin
                check("r_first_cs", mem_cs, 1);
                check("r_first_addr", mem_addr, tgt);
                check("r_flushed", level, 0);
            end
            check("r_valid_lat", op_valid, j >= 3);
            if (op_valid) pop_compare("r");
            advance();
        end
        check("r_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_cnt;
        logic [15:0] last_addr;
        int nxt3, nxt8, cnt3, cnt8, max3;

        rst = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; op_ready = 1'b0;

        // sequential fetch, one byte per cycle
        fetch_en = 1'b1; op_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("a_cs", mem_cs, 1);
            check("a_addr", mem_addr, 32'(k));
            check("a_valid", op_valid, k >= 2);
            if (op_valid) begin
                check("a_pc", op_pc, 32'(k - 2));
                check("a_data", op_data, 32'((k - 2) & 8'hFF));
            end
            if (k == 5) check("a_level", level, 1);
            advance();
        end

        // backpressure: credit limits to DEPTH requests
        op_ready = 1'b0;
        do_reset();
        cs_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_cs) cs_cnt++;
            advance();
        end
        check("b_issued", cs_cnt, 4);
        op_ready = 1'b1;
        @(negedge clk);
        check("b_full_level", level, 4);
        check("b_full_cs", mem_cs, 0);
        check("b_head_pc", op_pc, 16'h0000);
        advance();
        op_ready = 1'b0;
        cs_cnt = 0; last_addr = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_cs) begin
                cs_cnt++;
                last_addr = mem_addr;
            end
            advance();
        end
        check("b_one_more", cs_cnt, 1);
        check("b_one_addr", last_addr, 16'h0004);
        check("b_refill_level", level, 4);
        fetch_en = 1'b0; op_ready = 1'b1;
        exp_q.delete();
        for (int i = 1; i <= 4; i++) exp_q.push_back({16'(i), 8'(i)});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (op_valid) pop_compare("b");
            advance();
        end
        check("b_drain_left", exp_q.size(), 0);
        check("b_drain_level", level, 0);

        // redirect with a read in flight and a partly full queue
        fetch_en = 1'b1; op_ready = 1'b0;
        do_reset();
        repeat (3) advance();
        @(negedge clk);
        check("c_pre_level", level, 2);
        advance();
        run_redirect(sm83_fetch_pkg::CART_ENTRY_PC + 16'h0050);

        // address wrap at the top of the map
        run_redirect(16'hFFFE);

        // asynchronous reset mid-operation
        fetch_en = 1'b1; op_ready = 1'b0;
        do_reset();
        repeat (3) advance();
        #2;
        check("e_pre_level", level, 2);
        rst = 1'b0;
        #1;
        check("e_valid", op_valid, 0);
        check("e_level", level, 0);
        check("e_cs", mem_cs, 0);
        @(posedge clk);
        #1 rst = 1'b1; op_ready = 1'b1;
        @(negedge clk);
        check("e_restart_cs", mem_cs, 1);
        check("e_restart_addr", mem_addr, 16'h0000);
        advance();
        advance();
        @(negedge clk);
        check("e_first_valid", op_valid, 1);
        check("e_first_pc", op_pc, 16'h0000);
        advance();

        // sustained rate with MEM_LAT=3: DEPTH=4 throttles to 4 of 5, DEPTH=8 is full rate
        fetch_en = 1'b0;
        do_reset();
        nxt3 = 0; nxt8 = 0; cnt3 = 0; cnt8 = 0; max3 = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (op_valid_3) begin
                check("f3_pc", op_pc_3, 32'(nxt3));
                nxt3++;
                if (k >= 20) cnt3++;
            end
            if (op_valid_8) begin
                check("f8_pc", op_pc_8, 32'(nxt8));
                check("f8_data", op_data_8, 32'(nxt8 & 8'hFF));
                nxt8++;
                if (k >= 20) cnt8++;
            end
            if (int'(level_3) > max3) max3 = int'(level_3);
            advance();
        end
        check("f3_rate", cnt3, 32);
        check("f8_rate", cnt8, 40);
        check("f3_no_overflow", max3 <= 4, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
